// File: rtl/fft_host_port.sv
// Host-side streaming port for the DFT accelerator: buffers samples, streams them on R,
// collects W results into a 2-entry index-tagged FIFO, with a stall watchdog.
module fft_host_port #(
  parameter int N       = 2,
  parameter int DEPTH   = 4096,
  parameter int TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         n_Reset,
  input  logic         ld_we,
  input  logic [11:0]  ld_addr,
  input  logic [15:0]  ld_data,
  input  logic         start,
  input  logic [11:0]  samp_number,
  output logic [15:0]  RDATA,
  output logic         RVALID,
  input  logic         RREADY,
  input  logic [N-1:0] RBURST,
  input  logic [31:0]  WDATA,
  input  logic         WVALID,
  output logic         WREADY,
  input  logic [N-1:0] WBURST,
  output logic [31:0]  res_data,
  output logic [11:0]  res_index,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] last_rburst,
  output logic [N-1:0] last_wburst,
  output logic         busy,
  output logic         done,
  output logic         err_len,
  output logic         err_timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [12:0]   DEPTH_L = 13'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_RECV, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [11:0]   num_q, num_d, sent_q, sent_d, recv_q, recv_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          rvalid_q, rvalid_d, err_len_q, err_len_d;
  logic [N-1:0]  lrb_q, lrb_d, lwb_q, lwb_d;
  logic [31:0]   fdata_q [2], fdata_d [2];
  logic [11:0]   fidx_q [2], fidx_d [2];
  logic          frd_q, frd_d, fwr_q, fwr_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic [15:0]   rdata_q;
  logic [15:0]   mem [DEPTH];

  logic          idle_like, len_ok, ld_en, r_hs, w_hs, wready, pop, flush, rd_en;
  logic [AW-1:0] rd_addr;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign len_ok    = (samp_number != 12'd0) && ({1'b0, samp_number} <= DEPTH_L);
  assign ld_en     = n_Reset && ld_we && idle_like && ({1'b0, ld_addr} < DEPTH_L);
  assign r_hs      = rvalid_q && RREADY;
  // A full FIFO still accepts a result when the head is popped in the same cycle.
  assign wready    = (state_q == S_RECV) && (recv_q != num_q) && ((fcnt_q != 2'd2) || res_ready);
  assign w_hs      = wready && WVALID;
  assign pop       = (fcnt_q != 2'd0) && res_ready;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    sent_d    = sent_q;
    recv_d    = recv_q;
    wd_d      = wd_q;
    rvalid_d  = rvalid_q;
    lrb_d     = lrb_q;
    lwb_d     = lwb_q;
    fdata_d   = fdata_q;
    fidx_d    = fidx_q;
    frd_d     = frd_q;
    fwr_d     = fwr_q;
    fcnt_d    = fcnt_q;
    rd_en     = 1'b0;
    rd_addr   = sent_q[AW-1:0];
    flush     = 1'b0;
    err_len_d = start && idle_like && !len_ok;

    if (w_hs) begin
      fdata_d[fwr_q] = WDATA;
      fidx_d[fwr_q]  = recv_q;
      fwr_d          = ~fwr_q;
    end
    if (pop) frd_d = ~frd_q;
    case ({w_hs, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase

    case (state_q)
      S_SEND: begin
        if (r_hs) begin
          lrb_d  = RBURST;
          sent_d = sent_q + 12'd1;
          wd_d   = '0;
          if (sent_d == num_q) begin
            state_d  = S_RECV;
            rvalid_d = 1'b0;
          end else begin
            rd_en   = 1'b1;
            rd_addr = sent_d[AW-1:0];
          end
        end else begin
          wd_d = wd_q + WW'(1);
          // First SEND cycle: fetch entry 0 into the output register.
          if (!rvalid_q) begin
            rd_en    = 1'b1;
            rvalid_d = 1'b1;
          end
          if (wd_q == WD_LAST) begin
            state_d  = S_ERR;
            rvalid_d = 1'b0;
            rd_en    = 1'b0;
            flush    = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (w_hs) begin
          lwb_d  = WBURST;
          recv_d = recv_q + 12'd1;
          wd_d   = '0;
        end else begin
          wd_d = wd_q + WW'(1);
        end
        if ((recv_d == num_q) && (fcnt_d == 2'd0)) begin
          state_d = S_DONE;
        end else if (!w_hs && (wd_q == WD_LAST)) begin
          state_d = S_ERR;
          flush   = 1'b1;
        end
      end
      default: begin
        if (start && len_ok) begin
          state_d  = S_SEND;
          num_d    = samp_number;
          sent_d   = '0;
          recv_d   = '0;
          wd_d     = '0;
          rvalid_d = 1'b0;
          flush    = 1'b1;
        end
      end
    endcase

    if (flush) begin
      frd_d  = 1'b0;
      fwr_d  = 1'b0;
      fcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_Reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      wd_q      <= '0;
      rvalid_q  <= 1'b0;
      err_len_q <= 1'b0;
      lrb_q     <= '0;
      lwb_q     <= '0;
      fdata_q   <= '{default: '0};
      fidx_q    <= '{default: '0};
      frd_q     <= 1'b0;
      fwr_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      wd_q      <= wd_d;
      rvalid_q  <= rvalid_d;
      err_len_q <= err_len_d;
      lrb_q     <= lrb_d;
      lwb_q     <= lwb_d;
      fdata_q   <= fdata_d;
      fidx_q    <= fidx_d;
      frd_q     <= frd_d;
      fwr_q     <= fwr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_Reset) rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr[AW-1:0]] <= ld_data;
  end

  assign RDATA       = rdata_q;
  assign RVALID      = rvalid_q;
  assign WREADY      = wready;
  assign res_data    = fdata_q[frd_q];
  assign res_index   = fidx_q[frd_q];
  assign res_valid   = (fcnt_q != 2'd0);
  assign last_rburst = lrb_q;
  assign last_wburst = lwb_q;
  assign busy        = (state_q == S_SEND) || (state_q == S_RECV);
  assign done        = (state_q == S_DONE);
  assign err_len     = err_len_q;
  assign err_timeout = (state_q == S_ERR);

endmodule

// File: tb/tb_fft_host_port.sv
// Bench for fft_host_port: transfer-level reference model feeding expectation queues,
// compared every cycle against the DUT outputs on the falling edge.
module tb_fft_host_port;
  localparam int N       = 2;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 16;
  localparam int AW      = $clog2(DEPTH);

  logic         clk = 1'b0;
  logic         n_Reset = 1'b0;
  logic         ld_we = 1'b0;
  logic [11:0]  ld_addr = '0;
  logic [15:0]  ld_data = '0;
  logic         start = 1'b0;
  logic [11:0]  samp_number = '0;
  logic [15:0]  RDATA;
  logic         RVALID;
  logic         RREADY = 1'b0;
  logic [N-1:0] RBURST = '0;
  logic [31:0]  WDATA = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [N-1:0] WBURST = '0;
  logic [31:0]  res_data;
  logic [11:0]  res_index;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] last_rburst, last_wburst;
  logic         busy, done, err_len, err_timeout;

  fft_host_port #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_Reset(n_Reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .samp_number(samp_number), .RDATA(RDATA), .RVALID(RVALID),
    .RREADY(RREADY), .RBURST(RBURST), .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .WBURST(WBURST), .res_data(res_data), .res_index(res_index), .res_valid(res_valid),
    .res_ready(res_ready), .last_rburst(last_rburst), .last_wburst(last_wburst),
    .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases 0 idle, 1 send, 2 recv, 3 done, 4 err.
  logic [15:0]  ref_mem [DEPTH];
  logic [15:0]  r_exp [$];
  logic [43:0]  res_exp [$];
  int           m_phase = 0, m_n = 0, m_sent = 0, m_k = 0, m_wd = 0, m_age = 0;
  bit           m_live = 0, m_err_len = 0;
  logic [N-1:0] m_lrb = '0, m_lwb = '0;

  always @(negedge clk) begin : model
    bit exp_rv, exp_wr, r_hs, w_hs, pop, idle_like;
    exp_rv = (m_phase == 1) && (m_age >= 1);
    exp_wr = (m_phase == 2) && (m_k < m_n) && ((res_exp.size() < 2) || res_ready);
    if (m_live) begin
      check("RVALID", RVALID, exp_rv);
      if (exp_rv && r_exp.size() > 0) check("RDATA", RDATA, r_exp[0]);
      check("WREADY", WREADY, exp_wr);
      check("busy", busy, (m_phase == 1) || (m_phase == 2));
      check("done", done, m_phase == 3);
      check("err_timeout", err_timeout, m_phase == 4);
      check("err_len", err_len, m_err_len);
      check("res_valid", res_valid, res_exp.size() > 0);
      if (res_exp.size() > 0) check("res_head", {res_data, res_index}, res_exp[0]);
      check("last_rburst", last_rburst, m_lrb);
      check("last_wburst", last_wburst, m_lwb);
    end
    if (!n_Reset) begin
      m_live = 1; m_phase = 0; m_err_len = 0; m_lrb = '0; m_lwb = '0;
      m_n = 0; m_sent = 0; m_k = 0; m_wd = 0; m_age = 0;
      r_exp.delete(); res_exp.delete();
    end else if (m_live) begin
      idle_like = (m_phase == 0) || (m_phase == 3) || (m_phase == 4);
      r_hs = exp_rv && RREADY;
      w_hs = exp_wr && WVALID;
      pop  = (res_exp.size() > 0) && res_ready;
      if (ld_we && idle_like && ld_addr < DEPTH) ref_mem[ld_addr[AW-1:0]] = ld_data;
      m_err_len = start && idle_like && (samp_number == 0 || samp_number > DEPTH);
      case (m_phase)
        1: begin
          m_age++;
          if (r_hs) begin
            m_lrb = RBURST;
            void'(r_exp.pop_front());
            m_sent++;
            m_wd = 0;
            if (m_sent == m_n) m_phase = 2;
          end else begin
            m_wd++;
            if (m_wd == TIMEOUT) begin m_phase = 4; r_exp.delete(); end
          end
        end
        2: begin
          if (pop) void'(res_exp.pop_front());
          if (w_hs) begin
            res_exp.push_back({WDATA, 12'(m_k)});
            m_k++;
            m_lwb = WBURST;
            m_wd = 0;
          end else begin
            m_wd++;
          end
          if (m_k == m_n && res_exp.size() == 0) m_phase = 3;
          else if (!w_hs && m_wd == TIMEOUT) begin m_phase = 4; res_exp.delete(); end
        end
        default: begin
          if (start && idle_like && samp_number != 0 && samp_number <= DEPTH) begin
            m_phase = 1; m_n = int'(samp_number); m_sent = 0; m_k = 0; m_wd = 0; m_age = 0;
            r_exp.delete(); res_exp.delete();
            for (int i = 0; i < m_n; i++) r_exp.push_back(ref_mem[i]);
          end
        end
      endcase
    end
  end

  // Handshake-side drivers; modes select ready/valid patterns.
  int rr_mode = 0, wv_mode = 0, wd_mode = 0, rs_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       RREADY = 1'b1;
      1:       RREADY = ($urandom_range(0, 3) != 0);
      2:       RREADY = ~RREADY;
      3:       RREADY = (m_sent < 2);
      default: RREADY = 1'b0;
    endcase
    RBURST    = N'($urandom);
    WBURST    = N'($urandom);
    WVALID    = (wv_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    WDATA     = (wd_mode == 0) ? 32'hA000_0000 + 32'(m_k) : $urandom;
    res_ready = (rs_mode == 0) ? 1'b1 : (rs_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    ld_we = 1'b1; ld_addr = 12'(a); ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic fire_start(input int n);
    start = 1'b1; samp_number = 12'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int c = 0;
    while (!(done || err_timeout) && c < budget) begin tick(); c++; end
    check({name, "_bound"}, c < budget, 1'b1);
  endtask

  task automatic wait_resv(input string name, input int budget);
    int c = 0;
    while (!res_valid && c < budget) begin tick(); c++; end
    check({name, "_bound"}, c < budget, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 n_Reset = 1'b1;
    check("rst_RDATA", RDATA, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_index", res_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_to", err_timeout, 0);

    // Length errors from IDLE
    fire_start(0);
    check("len0_pulse", err_len, 1);
    tick();
    check("len0_clear", err_len, 0);
    fire_start(DEPTH + 1);
    check("lenbig_pulse", err_len, 1);
    check("lenbig_idle", busy, 0);
    tick();
    check("lenbig_clear", err_len, 0);
    check("lenbig_rvalid", RVALID, 0);

    for (int i = 0; i < DEPTH; i++) load(i, 16'($urandom));

    // Basic transfer
    for (int i = 0; i < 4; i++) load(i, 16'(i + 1));
    rr_mode = 0; wv_mode = 0; wd_mode = 0; rs_mode = 0;
    fire_start(4);
    check("basic_busy_rise", busy, 1);
    check("basic_rv_lat", RVALID, 0);
    tick();
    check("basic_rv_first", RVALID, 1);
    check("basic_rdata0", RDATA, 16'h0001);
    wait_end("basic", 100);
    check("basic_done", done, 1);
    check("basic_busy", busy, 0);

    // Backpressure
    for (int i = 0; i < 8; i++) load(i, 16'($urandom));
    wd_mode = 1; rr_mode = 2; rs_mode = 2;
    fire_start(8);
    wait_resv("bp_resv", 100);
    repeat (5) tick();
    check("bp_wready_full", WREADY, 0);
    check("bp_resv_held", res_valid, 1);
    rs_mode = 0;
    wait_end("bp", 200);
    check("bp_done", done, 1);

    // Watchdog
    rr_mode = 3;
    fire_start(6);
    wait_end("wd", 100);
    check("wd_err", err_timeout, 1);
    check("wd_rvalid", RVALID, 0);
    rr_mode = 0;
    fire_start(6);
    wait_end("wd_restart", 100);
    check("wd_restart_done", done, 1);

    // Start and load while busy
    fire_start(10);
    tick(); tick();
    start = 1'b1; samp_number = 12'd3;
    ld_we = 1'b1; ld_addr = 12'd0; ld_data = 16'hDEAD;
    tick();
    start = 1'b0; ld_we = 1'b0;
    check("busy_ign_busy", busy, 1);
    wait_end("busy_ign", 200);
    check("busy_ign_done", done, 1);
    fire_start(10);
    wait_end("busy_reread", 200);
    check("busy_reread_done", done, 1);

    // Reset during RECV
    rs_mode = 2;
    fire_start(8);
    wait_resv("rst_mid_resv", 100);
    n_Reset = 1'b0;
    tick();
    n_Reset = 1'b1;
    check("rmid_res_valid", res_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_rvalid", RVALID, 0);
    check("rmid_wready", WREADY, 0);
    check("rmid_RDATA", RDATA, 0);
    check("rmid_res_data", res_data, 0);
    check("rmid_res_index", res_index, 0);
    check("rmid_lrb", last_rburst, 0);
    rs_mode = 0;
    fire_start(8);
    wait_end("rmid_after", 200);
    check("rmid_after_done", done, 1);

    // Randomised transfers, first one at full DEPTH
    for (int it = 0; it < 6; it++) begin
      int n;
      for (int j = 0; j < 4; j++) load($urandom_range(0, DEPTH - 1), 16'($urandom));
      rr_mode = 1; wv_mode = 1; wd_mode = 1; rs_mode = 1;
      n = (it == 0) ? DEPTH : $urandom_range(1, 20);
      fire_start(n);
      wait_end("rand", 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
